// File: rtl/video_pkg.sv
// video_pkg: shared video coordinate widths, FSM states and grid pattern coding
package video_pkg;
  localparam int COORD_W = 12;
  localparam int PIX_W = 8;
  localparam logic [COORD_W-1:0] NONE_COORD = 12'hFFF;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CHECK} state_t;
  // Same coding as the grid source: red grid lines every 8, green/blue 16-wide bands
  function automatic logic [3*PIX_W-1:0] grid_rgb(input logic on, input logic [COORD_W-1:0] h,
                                                  input logic [COORD_W-1:0] v);
    logic r, g, b;
    r = on & (h[2:0] == 3'd0 | v[2:0] == 3'd0);
    g = on & v[4];
    b = on & h[4];
    return {{PIX_W{r}}, {PIX_W{g}}, {PIX_W{b}}};
  endfunction
endpackage

// File: rtl/coord_delay_line.sv
// coord_delay_line: DEPTH-stage shift register with synchronous clear, async active-low reset
module coord_delay_line #(
  parameter int DEPTH = 2,
  parameter int W = 26
)(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_sr [DEPTH];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sr <= '{default: '0};
    else if (i_clr) r_sr <= '{default: '0};
    else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/test_pattern_checker.sv
// test_pattern_checker: regenerates the grid pattern and checks received RGB per frame
module test_pattern_checker
  import video_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W = 24,
  parameter int LOCK_FRAMES = 4
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               display_on,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic [PIX_W-1:0]   rgb_r,
  input  logic [PIX_W-1:0]   rgb_g,
  input  logic [PIX_W-1:0]   rgb_b,
  output logic               frame_done,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   pix_count,
  output logic               frame_pass,
  output logic [COORD_W-1:0] first_err_hpos,
  output logic [COORD_W-1:0] first_err_vpos,
  output logic               locked
);
  localparam int DL_W = 2 + 2*COORD_W;
  logic [DL_W-1:0] w_dl;
  logic w_d_valid, w_d_on, w_chk, w_mis, w_sof, w_start, w_run, w_frame_end, w_pass;
  logic [COORD_W-1:0] w_d_h, w_d_v;
  logic [3:0] w_run_next;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_acc_err, r_acc_pix;
  logic [COORD_W-1:0] r_acc_fh, r_acc_fv;
  logic [3:0] r_pass_run;
  coord_delay_line #(.DEPTH(LATENCY), .W(DL_W)) u_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (!enable),
    .i_d     ({enable, display_on, hpos, vpos}),
    .o_q     (w_dl)
  );
  assign {w_d_valid, w_d_on, w_d_h, w_d_v} = w_dl;
  assign w_chk = w_d_valid & w_d_on;
  assign w_mis = w_chk & ({rgb_r, rgb_g, rgb_b} != grid_rgb(w_d_on, w_d_h, w_d_v));
  assign w_sof = w_d_valid & (w_d_h == '0) & (w_d_v == '0);
  assign w_start = enable & (r_state != IDLE) & w_sof;
  assign w_frame_end = enable & (r_state == CHECK) & w_sof;
  assign w_run = enable & (r_state == CHECK);
  assign w_pass = (r_acc_err == '0) & (r_acc_pix != '0);
  assign w_run_next = !w_pass ? 4'd0 : (r_pass_run == 4'(LOCK_FRAMES)) ? r_pass_run : r_pass_run + 4'd1;
  always_comb w_next = !enable ? IDLE : (r_state == IDLE) ? WAIT_SOF :
                       (r_state == WAIT_SOF && w_sof) ? CHECK : r_state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // The sof pixel opens the new frame, so it seeds the accumulators rather than adding
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_acc_err <= '0;
      r_acc_pix <= '0;
      r_acc_fh <= NONE_COORD;
      r_acc_fv <= NONE_COORD;
    end else if (w_start) begin
      r_acc_err <= CNT_W'(w_mis);
      r_acc_pix <= CNT_W'(w_chk);
      r_acc_fh <= w_mis ? w_d_h : NONE_COORD;
      r_acc_fv <= w_mis ? w_d_v : NONE_COORD;
    end else if (w_run) begin
      r_acc_err <= r_acc_err + CNT_W'(w_mis & ~&r_acc_err);
      r_acc_pix <= r_acc_pix + CNT_W'(w_chk & ~&r_acc_pix);
      if (w_mis && r_acc_err == '0) begin
        r_acc_fh <= w_d_h;
        r_acc_fv <= w_d_v;
      end
    end else begin
      r_acc_err <= '0;
      r_acc_pix <= '0;
      r_acc_fh <= NONE_COORD;
      r_acc_fv <= NONE_COORD;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      frame_done <= 1'b0;
      err_count <= '0;
      pix_count <= '0;
      frame_pass <= 1'b0;
      first_err_hpos <= NONE_COORD;
      first_err_vpos <= NONE_COORD;
      r_pass_run <= '0;
      locked <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (w_frame_end) begin
        err_count <= r_acc_err;
        pix_count <= r_acc_pix;
        frame_pass <= w_pass;
        first_err_hpos <= r_acc_fh;
        first_err_vpos <= r_acc_fv;
        r_pass_run <= w_run_next;
        locked <= (w_run_next == 4'(LOCK_FRAMES));
      end
    end
endmodule

// File: tb/tb_test_pattern_checker.sv
// tb_test_pattern_checker: looped-back 64x16 grid source with injected faults and a frame-level model
module tb_test_pattern_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0, enable = 1'b0, display_on = 1'b0;
  logic [11:0] hpos = '0, vpos = '0;
  logic [7:0] rgb_r = '0, rgb_g = '0, rgb_b = '0;
  logic fd_a, pass_a, lk_a, fd_s, pass_s, lk_s;
  logic [23:0] err_a, pix_a;
  logic [3:0] err_s, pix_s;
  logic [11:0] fh_a, fv_a, fh_s, fv_s;

  test_pattern_checker #(.LATENCY(2), .CNT_W(24), .LOCK_FRAMES(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .frame_done(fd_a), .err_count(err_a), .pix_count(pix_a),
    .frame_pass(pass_a), .first_err_hpos(fh_a), .first_err_vpos(fv_a), .locked(lk_a));
  test_pattern_checker #(.LATENCY(2), .CNT_W(4), .LOCK_FRAMES(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .frame_done(fd_s), .err_count(err_s), .pix_count(pix_s),
    .frame_pass(pass_s), .first_err_hpos(fh_s), .first_err_vpos(fv_s), .locked(lk_s));

  typedef struct {bit en; bit on; int h; int v; int f;} pix_t;
  typedef struct {int mode; int err; int pix; int pass; int fh; int fv; int lk; int serr; int spix;} row_t;
  int tests = 0, fails = 0, cyc = 0;
  int gh = 79, gv = 19, gf = -1;
  pix_t cur, p1, p2;
  bit en_req = 0, rst_req = 0;
  int mode_q[$];
  logic [23:0] act [2][16][64];
  int e_err[2], e_pix[2], e_fh[2], e_fv[2];
  bit started = 0, fd_pend = 0;
  int cur_f = 0, rep_f = -1, run = 0;
  int m_err = 0, m_pix = 0, m_pass = 0, m_fh = 'hFFF, m_fv = 'hFFF, m_lk = 0;

  task automatic chk(string n, longint a, longint e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic logic [23:0] ref_pix(int h, int v);
    logic r, g, b;
    r = (h % 8 == 0) || (v % 8 == 0);
    g = ((v / 16) % 2) == 1;
    b = ((h / 16) % 2) == 1;
    return {{8{r}}, {8{g}}, {8{b}}};
  endfunction

  // Per-frame picture the source actually sends, plus its expected statistics in raster order
  task automatic build_frame(int f);
    int mode, b, n, rh, rv;
    mode = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
    b = f & 1;
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 64; h++) begin
        act[b][v][h] = ref_pix(h, v);
        if (mode == 1 && h == 5 && v == 3) act[b][v][h][15:8] = 8'hFE;
        if (mode == 2) act[b][v][h][23:16] = 8'hFF;
      end
    if (mode == 3) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        rh = $urandom_range(0, 63);
        rv = $urandom_range(0, 15);
        act[b][rv][rh] = act[b][rv][rh] ^ 24'($urandom_range(1, 24'hFFFFFF));
      end
    end
    e_err[b] = 0; e_pix[b] = 0; e_fh[b] = 'hFFF; e_fv[b] = 'hFFF;
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 64; h++) begin
        e_pix[b]++;
        if (act[b][v][h] != ref_pix(h, v)) begin
          if (e_err[b] == 0) begin e_fh[b] = h; e_fv[b] = v; end
          e_err[b]++;
        end
      end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("frame_done", fd_a, fd_pend);
    chk("frame_done_s", fd_s, fd_pend);
    if (fd_pend) begin
      chk("err_count", err_a, m_err);
      chk("pix_count", pix_a, m_pix);
      chk("frame_pass", pass_a, m_pass);
      chk("first_h", fh_a, m_fh);
      chk("first_v", fv_a, m_fv);
      chk("locked", lk_a, m_lk);
      chk("sat_err", err_s, m_err > 15 ? 15 : m_err);
      chk("sat_pix", pix_s, m_pix > 15 ? 15 : m_pix);
      chk("sat_pass", pass_s, m_pass);
      chk("sat_first_h", fh_s, m_fh);
      chk("sat_locked", lk_s, m_lk);
    end
    fd_pend = 0;
    reset_n = rst_req;
    p2 = p1;
    p1 = cur;
    if (!en_req) p1.en = 0;
    gh++;
    if (gh == 80) begin gh = 0; gv++; end
    if (gv == 20) begin gv = 0; gf++; build_frame(gf); end
    cur = '{en: en_req && rst_req, on: (gh < 64 && gv < 16), h: gh, v: gv, f: gf};
    enable = en_req;
    display_on = cur.on;
    hpos = 12'(cur.h);
    vpos = 12'(cur.v);
    {rgb_r, rgb_g, rgb_b} = p2.on ? act[p2.f & 1][p2.v][p2.h] : 24'($urandom);
    if (!en_req) started = 0;
    if (p2.en && en_req && rst_req && p2.h == 0 && p2.v == 0) begin
      if (started) begin
        m_err = e_err[cur_f & 1];
        m_pix = e_pix[cur_f & 1];
        m_fh = e_fh[cur_f & 1];
        m_fv = e_fv[cur_f & 1];
        m_pass = (m_err == 0 && m_pix != 0);
        run = m_pass ? (run < 4 ? run + 1 : 4) : 0;
        m_lk = (run == 4);
        rep_f = cur_f;
        fd_pend = 1;
      end
      started = 1;
      cur_f = p2.f;
    end
    cyc++;
  endtask

  task automatic wait_fd();
    int t;
    t = 0;
    do begin tick(); t++; end while (!fd_a && t < 4000);
    if (!fd_a) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_frame(int tgt);
    int k;
    k = 0;
    do begin wait_fd(); k++; end while (rep_f != tgt && k < 5);
    chk("frame_reported", rep_f, tgt);
  endtask

  row_t rows [3];
  int tgt, t0;

  initial begin
    rows[0] = '{mode: 0, err: 0, pix: 1024, pass: 1, fh: 'hFFF, fv: 'hFFF, lk: 0, serr: 0, spix: 15};
    rows[1] = '{mode: 1, err: 1, pix: 1024, pass: 0, fh: 5, fv: 3, lk: 0, serr: 1, spix: 15};
    rows[2] = '{mode: 2, err: 784, pix: 1024, pass: 0, fh: 1, fv: 1, lk: 0, serr: 15, spix: 15};
    repeat (5) tick();
    chk("rst_frame_done", fd_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_pix", pix_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_first_h", fh_a, 'hFFF);
    chk("rst_first_v", fv_a, 'hFFF);
    chk("rst_locked", lk_a, 0);
    rst_req = 1;
    repeat (3) tick();
    en_req = 1;
    for (int i = 0; i < 3; i++) begin
      mode_q.push_back(rows[i].mode);
      tgt = gf + 1;
      wait_frame(tgt);
      chk("row_err", err_a, rows[i].err);
      chk("row_pix", pix_a, rows[i].pix);
      chk("row_pass", pass_a, rows[i].pass);
      chk("row_first_h", fh_a, rows[i].fh);
      chk("row_first_v", fv_a, rows[i].fv);
      chk("row_locked", lk_a, rows[i].lk);
      chk("row_sat_err", err_s, rows[i].serr);
      chk("row_sat_pix", pix_s, rows[i].spix);
      if (i == 0) begin
        repeat (3) wait_fd();
        chk("lock_5th_sof", lk_a, 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      wait_fd();
      chk("relock_after_fail", lk_a, i == 3);
    end
    repeat (5) mode_q.push_back(3);
    repeat (6) wait_fd();
    while (!(gv == 8 && gh == 10)) tick();
    en_req = 0;
    repeat (30) tick();
    chk("hold_err", err_a, m_err);
    chk("hold_pix", pix_a, m_pix);
    chk("hold_pass", pass_a, m_pass);
    chk("hold_locked", lk_a, m_lk);
    en_req = 1;
    t0 = cyc;
    wait_fd();
    chk("reen_second_sof", (cyc - t0) > 1600, 1);
    chk("reen_full_pix", pix_a, 1024);
    for (int i = 0; i < 6 && !lk_a; i++) wait_fd();
    chk("locked_before_reset", lk_a, 1);
    while (gv != 6) tick();
    #3;
    reset_n = 0;
    rst_req = 0;
    cur.en = 0; p1.en = 0; p2.en = 0;
    started = 0; fd_pend = 0; run = 0;
    m_err = 0; m_pix = 0; m_pass = 0; m_fh = 'hFFF; m_fv = 'hFFF; m_lk = 0;
    #1;
    chk("async_err", err_a, 0);
    chk("async_pix", pix_a, 0);
    chk("async_pass", pass_a, 0);
    chk("async_first_h", fh_a, 'hFFF);
    chk("async_first_v", fv_a, 'hFFF);
    chk("async_locked", lk_a, 0);
    chk("async_locked_s", lk_s, 0);
    repeat (3) tick();
    rst_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_fd();
      chk("lock_after_reset", lk_a, i == 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/test_pattern_checker.md
Name: test_pattern_checker

Overview:
- Sink-side counterpart of the grid test-pattern source; sits on the pixel bus at the far end of the video path, in loopback, or after a scaler.
- Takes the same hpos/vpos/display_on timing the source receives, regenerates the expected grid pattern with matching pipeline delay, and compares it against the incoming RGB bytes.
- Reports per-frame error and pixel counts, the first failing coordinate, and a lock flag for self-test and bring-up.

Parameters:
- LATENCY, 2, clocks between hpos/vpos/display_on presentation and the matching rgb arrival (1..8).
- CNT_W, 24, width of the error and pixel counters.
- LOCK_FRAMES, 4, consecutive passing frames required to assert locked (1..15).

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  checker run; 0 = idle, accumulators cleared
- display_on  in  1  active-video flag, same timing as the source input
- hpos  in  12  horizontal position
- vpos  in  12  vertical position
- rgb_r  in  8  received red, LATENCY clocks after coordinates
- rgb_g  in  8  received green
- rgb_b  in  8  received blue
- frame_done  out  1  one-clock pulse; result outputs updated
- err_count  out  CNT_W  mismatched active pixels in last completed frame
- pix_count  out  CNT_W  active pixels checked in last completed frame
- frame_pass  out  1  last completed frame had err_count==0 and pix_count!=0
- first_err_hpos  out  12  hpos of first mismatch in last frame, 12'hFFF if none
- first_err_vpos  out  12  vpos of first mismatch, 12'hFFF if none
- locked  out  1  LOCK_FRAMES consecutive passing frames

Behaviour:
- Reset (async, reset_n=0): frame_done=0, err_count=0, pix_count=0, frame_pass=0, first_err_*=12'hFFF, locked=0, pass-run counter=0, delay line cleared with valid=0, state=IDLE.
- Delay line: LATENCY-deep shift register carrying {valid, display_on, hpos, vpos}. valid enters as 1 while enable=1. Delayed values are d_on, d_h, d_v.
- Expected pattern on the delayed stage:
  - exp_r = d_on & (d_h[2:0]==0 | d_v[2:0]==0)
  - exp_g = d_on & d_v[4]
  - exp_b = d_on & d_h[4]
  - Each expected channel byte is {8{exp}}.
- Compare is strict byte equality; any channel differing = one pixel error. Only cycles with d_valid & d_on are checked or counted. Blanking rgb is ignored.
- sof = d_valid & d_h==0 & d_v==0.
- FSM:
  - IDLE: enable=1 -> WAIT_SOF.
  - WAIT_SOF: discards the partial frame; on sof -> CHECK, accumulators start at this pixel.
  - CHECK: accumulate every checked pixel. On each sof, register the results of the finished frame and clear the accumulators; the sof pixel itself counts toward the new frame, including a mismatch on that same cycle.
  - enable=0 from any state -> IDLE next clock: accumulators and delay line cleared, result outputs and locked held.
- Result timing: sof in cycle N -> frame_done=1 in N+1 only. err_count, pix_count, frame_pass and first_err_* are valid from N+1 and held until the next frame_done.
- first_err latches the delayed coordinates of the first mismatch in a frame; later mismatches do not overwrite it.
- Accumulators saturate at all-ones and do not wrap.
- Pass-run counter:
  - Passing frame: increments, saturating at LOCK_FRAMES.
  - Failing frame: clears it.
  - locked = (counter==LOCK_FRAMES), updated with frame_done.
- Reset mid-frame: all state returns to reset values immediately; a new check starts at the next sof after reset_n=1 and enable=1.

Decomposition:
- Shared package video_pkg: COORD_W=12, pixel byte width 8, NONE_COORD=12'hFFF, FSM state enum {IDLE, WAIT_SOF, CHECK}.
- The expected-pattern function is shared with the source's coding.
- One natural sub-module: coord_delay_line (parameterised depth/width, async active-low reset), reusable for other sink-side video blocks.

Test Plan:
- Toy timing is 64x16 active inside 80x20 total. Source output is looped back with 2-clock delay, LOCATENCY=2 and LOCK_FRAMES=4. Required at the 2nd sof: frame_done pulse, err_count=0, pix_count=1024, frame_pass=1, first_err=(FFF,FFF). locked=1 at the 5th sof.
- Force rgb_g=8'hFE only at (h=5,v=3) for one frame -> err_count=1, first_err_hpos=5, first_err_vpos=3, frame_pass=0, locked=0. The following frames pass, and locked re-asserts after 4 passing frames.
- Force rgb_r=8'hFF on all active pixels -> err_count=784 (56 columns x 14 rows where exp_r=0), pix_count=1024, frame_pass=0.
- With CNT_W=4 and the same forced red -> err_count saturates at 15 and pix_count at 15, with no wrap.
- Drop enable for 30 clocks mid-frame, then re-raise -> no frame_done until the 2nd sof after re-enable. Outputs hold their prior values throughout, and the first new result reports a full 1024-pixel frame.
- Assert reset_n=0 asynchronously mid-CHECK with locked=1 -> all outputs return to reset values within the same cycle, and locked stays 0 until 4 new passing frames.
